// File: rtl/complex_alu.sv
// complex_alu: sequential complex-arithmetic unit for the 16x64 register bank.
// Operands arrive as {real, imag} words. The result goes back through the
// bank write port. Complex multiplies share one signed PW x PW multiplier
// over four cycles.
module complex_alu #(
   parameter int PW = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        opcode,
   input  logic [3:0]        dest,
   input  logic [2*PW-1:0]   opA,
   input  logic [2*PW-1:0]   opB,
   output logic              busy,
   output logic              done,
   output logic              ovf,
   output logic [2*PW-1:0]   inA,
   output logic              regwen,
   output logic [3:0]        selwreg,
   output logic [1:0]        endwreg
);

   // Accumulator width: a full product plus headroom for one add/subtract.
   localparam int AW = 2*PW + 2;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_MUL  = 3'b010,
      OP_CMUL = 3'b011,
      OP_CONJ = 3'b100,
      OP_NEG  = 3'b101,
      OP_SWAP = 3'b110,
      OP_NOP  = 3'b111
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE, S_EX, S_M0, S_M1, S_M2, S_M3, S_WB
   } state_t;

   state_t                  state;
   op_t                     op_q;
   logic [3:0]              dest_q;
   logic signed [PW-1:0]    ar, ai, br, bi;
   logic signed [AW-1:0]    re, im;

   logic signed [PW-1:0]    mul_a, mul_b;
   logic signed [2*PW-1:0]  mul_ax, mul_bx, prod;

   // Sign-extend one part to accumulator width.
   function automatic logic signed [AW-1:0] ext_w(input logic signed [PW-1:0] v);
      return {{(AW-PW){v[PW-1]}}, v};
   endfunction

   // Sign-extend a product to accumulator width.
   function automatic logic signed [AW-1:0] ext_p(input logic signed [2*PW-1:0] v);
      return {{(AW-2*PW){v[2*PW-1]}}, v};
   endfunction

   // True when the exact value fits in a PW-bit signed part.
   function automatic logic in_range(input logic signed [AW-1:0] v);
      logic [AW-PW:0] top;
      top = v[AW-1:PW-1];
      return (&top) | ~(|top);
   endfunction

   // Select the multiplier operands for the current multiply step.
   always_comb begin
      // NOTE: defaults first so every path assigns both operands and no latch is inferred.
      mul_a = ar;
      mul_b = br;
      case (state)
         S_M1:    begin mul_a = ai; mul_b = bi; end
         S_M2:    begin mul_a = ar; mul_b = bi; end
         S_M3:    begin mul_a = ai; mul_b = br; end
         default: begin mul_a = ar; mul_b = br; end
      endcase
   end

   assign mul_ax = {{PW{mul_a[PW-1]}}, mul_a};
   assign mul_bx = {{PW{mul_b[PW-1]}}, mul_b};
   assign prod   = mul_ax * mul_bx;

   // Control FSM, datapath accumulators and registered bank write port.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         regwen  <= 1'b0;
         ovf     <= 1'b0;
         inA     <= '0;
         selwreg <= '0;
         endwreg <= '0;
         re      <= '0;
         im      <= '0;
         op_q    <= OP_NOP;
         dest_q  <= '0;
         ar      <= '0;
         ai      <= '0;
         br      <= '0;
         bi      <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         done   <= 1'b0;
         regwen <= 1'b0;
         case (state)
            S_IDLE: begin
               if (busy) begin
                  // Write-back cycle: start is ignored here.
                  busy <= 1'b0;
               end else if (start) begin
                  op_q   <= op_t'(opcode);
                  dest_q <= dest;
                  ar     <= opA[2*PW-1:PW];
                  ai     <= opA[PW-1:0];
                  br     <= opB[2*PW-1:PW];
                  bi     <= opB[PW-1:0];
                  busy   <= 1'b1;
                  state  <= (opcode == OP_MUL || opcode == OP_CMUL) ? S_M0 : S_EX;
               end
            end
            S_EX: begin
               case (op_q)
                  OP_ADD:  begin re <= ext_w(ar) + ext_w(br); im <= ext_w(ai) + ext_w(bi); end
                  OP_SUB:  begin re <= ext_w(ar) - ext_w(br); im <= ext_w(ai) - ext_w(bi); end
                  OP_CONJ: begin re <= ext_w(ar);             im <= -ext_w(ai);            end
                  OP_NEG:  begin re <= -ext_w(ar);            im <= -ext_w(ai);            end
                  OP_SWAP: begin re <= ext_w(ar);             im <= ext_w(ai);             end
                  default: begin re <= '0;                    im <= '0;                    end
               endcase
               state <= S_WB;
            end
            S_M0: begin
               re    <= ext_p(prod);
               state <= S_M1;
            end
            S_M1: begin
               re    <= (op_q == OP_CMUL) ? re + ext_p(prod) : re - ext_p(prod);
               state <= S_M2;
            end
            S_M2: begin
               im    <= (op_q == OP_CMUL) ? -ext_p(prod) : ext_p(prod);
               state <= S_M3;
            end
            S_M3: begin
               im    <= im + ext_p(prod);
               state <= S_WB;
            end
            S_WB: begin
               done    <= 1'b1;
               regwen  <= (op_q != OP_NOP);
               inA     <= {re[PW-1:0], im[PW-1:0]};
               ovf     <= ~(in_range(re) & in_range(im));
               selwreg <= dest_q;
               endwreg <= (op_q == OP_SWAP) ? 2'b11 : 2'b00;
               state   <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_complex_alu.sv
// tb_complex_alu: randomized self-checking bench for complex_alu against an
// arithmetic reference model of the complex operations.
module tb_complex_alu;

   typedef logic signed [95:0] wide_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  opcode = 3'd0;
   logic [3:0]  dest = 4'd0;
   logic [63:0] opA = 64'd0;
   logic [63:0] opB = 64'd0;
   logic        busy, done, ovf, regwen;
   logic [63:0] inA;
   logic [3:0]  selwreg;
   logic [1:0]  endwreg;

   int n_checks = 0;
   int n_errors = 0;

   complex_alu #(.PW(32)) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .opcode  (opcode),
      .dest    (dest),
      .opA     (opA),
      .opB     (opB),
      .busy    (busy),
      .done    (done),
      .ovf     (ovf),
      .inA     (inA),
      .regwen  (regwen),
      .selwreg (selwreg),
      .endwreg (endwreg)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference: exact complex arithmetic, then wrap and range check.
   function automatic void model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] res, output logic ov,
                                 output logic wen, output logic [1:0] ew);
      wide_t ar, ai, br, bi, re, im, lo, hi;
      ar = $signed(a[63:32]);
      ai = $signed(a[31:0]);
      br = $signed(b[63:32]);
      bi = $signed(b[31:0]);
      lo = -96'sd2147483648;
      hi = 96'sd2147483647;
      case (op)
         3'd0:    begin re = ar + br;           im = ai + bi;           end
         3'd1:    begin re = ar - br;           im = ai - bi;           end
         3'd2:    begin re = ar * br - ai * bi; im = ar * bi + ai * br; end
         3'd3:    begin re = ar * br + ai * bi; im = ai * br - ar * bi; end
         3'd4:    begin re = ar;                im = -ai;               end
         3'd5:    begin re = -ar;               im = -ai;               end
         3'd6:    begin re = ar;                im = ai;                end
         default: begin re = '0;                im = '0;                end
      endcase
      res = {re[31:0], im[31:0]};
      ov  = (re < lo) || (re > hi) || (im < lo) || (im > hi);
      wen = (op != 3'd7);
      ew  = (op == 3'd6) ? 2'b11 : 2'b00;
   endfunction

   function automatic logic [31:0] rpart();
      case ($urandom_range(0, 6))
         0:       return 32'h8000_0000;
         1:       return 32'h7FFF_FFFF;
         2:       return 32'h0000_0000;
         3:       return 32'hFFFF_FFFF;
         4:       return 32'($urandom_range(0, 200)) - 32'd100;
         default: return $urandom;
      endcase
   endfunction

   // One operation from start to the cycle after write-back. With disturb set,
   // start/opcode/dest/operands are scrambled on every edge while busy.
   task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] d, input bit disturb);
      logic [63:0] e_res;
      logic        e_ovf, e_wen;
      logic [1:0]  e_ew;
      int          lat, edge_n, writes;
      bit          seen;
      model(op, a, b, e_res, e_ovf, e_wen, e_ew);
      lat = (op == 3'd2 || op == 3'd3) ? 5 : 2;
      @(negedge clock);
      start = 1'b1; opcode = op; dest = d; opA = a; opB = b;
      @(posedge clock);
      @(negedge clock);
      check("busy_at_accept", busy, 1);
      start = 1'b0;
      edge_n = 0; writes = 0; seen = 0;
      while (!seen && edge_n < 20) begin
         if (disturb) begin
            start  = 1'b1;
            opcode = 3'($urandom);
            dest   = 4'($urandom);
            opA    = {$urandom, $urandom};
            opB    = {$urandom, $urandom};
         end
         @(posedge clock);
         edge_n++;
         @(negedge clock);
         if (regwen) writes++;
         if (done) seen = 1;
         else check("busy_running", busy, 1);
      end
      start = 1'b0;
      check("done_seen", seen, 1);
      check("latency", edge_n, lat);
      check("inA", inA, e_res);
      check("ovf", ovf, e_ovf);
      check("regwen", regwen, e_wen);
      check("selwreg", selwreg, d);
      check("endwreg", endwreg, e_ew);
      check("busy_wb", busy, 1);
      @(posedge clock);
      @(negedge clock);
      if (regwen) writes++;
      check("done_pulse_end", done, 0);
      check("regwen_pulse_end", regwen, 0);
      check("busy_end", busy, 0);
      check("ovf_held", ovf, e_ovf);
      check("write_count", writes, e_wen);
   endtask

   initial begin
      int first_done, second_done, n_done, pulses;
      logic [63:0] e_res;
      logic        e_ovf, e_wen;
      logic [1:0]  e_ew;

      // Reset state
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_regwen", regwen, 0);
      check("rst_ovf", ovf, 0);
      check("rst_inA", inA, 0);
      check("rst_selwreg", selwreg, 0);
      check("rst_endwreg", endwreg, 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // Directed vectors
      run_op(3'd2, 64'h00000003_00000004, 64'h00000001_00000002, 4'd5, 0);
      run_op(3'd3, 64'h00000003_00000004, 64'h00000001_00000002, 4'd6, 0);
      run_op(3'd0, 64'h00000001_00000001, 64'hFFFFFFFF_FFFFFFFF, 4'd7, 0);
      run_op(3'd0, 64'h7FFFFFFF_00000000, 64'h00000001_00000000, 4'd8, 0);
      run_op(3'd5, 64'h80000000_00000005, 64'h0, 4'd9, 0);
      run_op(3'd4, 64'h00000007_80000000, 64'h0, 4'd1, 0);
      run_op(3'd1, 64'h80000000_7FFFFFFF, 64'h00000001_FFFFFFFF, 4'd2, 0);
      run_op(3'd6, 64'h00000001_00000002, 64'h0, 4'd10, 0);
      run_op(3'd7, 64'h12345678_9ABCDEF0, 64'h11111111_22222222, 4'd11, 0);
      run_op(3'd3, 64'h80000000_80000000, 64'h80000000_80000000, 4'd12, 0);
      run_op(3'd2, 64'h80000000_80000000, 64'h80000000_7FFFFFFF, 4'd13, 0);

      // Start pulses and operand changes during an in-flight multiply
      run_op(3'd2, 64'h00000003_00000004, 64'h00000001_00000002, 4'd4, 1);
      run_op(3'd3, 64'hFFFFFFF0_00000011, 64'h00000005_FFFFFFFD, 4'd14, 1);

      // Start held high: a new accept only once busy has dropped
      model(3'd0, 64'h00000010_00000020, 64'h00000001_00000002, e_res, e_ovf, e_wen, e_ew);
      @(negedge clock);
      start = 1'b1; opcode = 3'd0; dest = 4'd3;
      opA = 64'h00000010_00000020; opB = 64'h00000001_00000002;
      first_done = -1; second_done = -1; n_done = 0;
      for (int e = 0; e <= 7; e++) begin
         @(posedge clock);
         @(negedge clock);
         if (done) begin
            n_done++;
            if (first_done < 0) first_done = e;
            else if (second_done < 0) second_done = e;
            check("held_inA", inA, e_res);
         end
      end
      start = 1'b0;
      check("held_first_done", first_done, 2);
      check("held_second_done", second_done, 6);
      check("held_done_count", n_done, 2);
      repeat (4) @(negedge clock);

      // Asynchronous reset during M2 of a multiply
      run_op(3'd0, 64'h7FFFFFFF_00000000, 64'h00000001_00000000, 4'd8, 0);
      @(negedge clock);
      start = 1'b1; opcode = 3'd2; dest = 4'd15;
      opA = 64'h00000003_00000004; opB = 64'h00000001_00000002;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_regwen", regwen, 0);
      check("mid_rst_ovf", ovf, 0);
      check("mid_rst_inA", inA, 0);
      @(negedge clock);
      reset = 1'b0;
      pulses = 0;
      for (int e = 0; e < 8; e++) begin
         @(negedge clock);
         if (regwen || done || busy) pulses++;
      end
      check("no_write_after_rst", pulses, 0);
      run_op(3'd0, 64'h00000002_00000003, 64'h00000004_FFFFFFFF, 4'd6, 0);

      // Randomized operations
      for (int i = 0; i < 60; i++) begin
         run_op(3'($urandom), {rpart(), rpart()}, {rpart(), rpart()}, 4'($urandom),
                ($urandom_range(0, 3) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
